approx_prod_accumulator: RTL and testbench
==========================================

Name: approx_prod_accumulator

Overview:
- Downstream consumer of the 8x8 approximate multiplier's 16-bit product R.
- Accumulates a group of products into a wide sum over a valid/ready stream and emits one result per group with a valid/ready handshake.
- The input group ends on an explicit last flag or when a configured maximum length is reached.
- Sits between the multiplier array and the dot-product / error-analysis logic; keeps the multiplier purely combinational.

Parameters:
- PROD_W, 16, width of the incoming product; matches the multiplier's R output.
- ACC_W, 24, accumulator and result width; must be >= PROD_W.
- MAX_LEN, 16, maximum products per group; must be >= 1.
- CNT_W, $clog2(MAX_LEN+1), width of the beat counter and the out_len port.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product beat valid.
- in_ready  output  1  block can accept a beat.
- in_prod  input  PROD_W  product from the multiplier (unsigned).
- in_last  input  1  this beat closes the group.
- out_valid  output  1  group result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  group sum.
- out_len  output  CNT_W  number of beats in the group (1..MAX_LEN).
- out_sat  output  1  saturation occurred in this group (SAT_EN only; otherwise tied 0).

Behaviour:
- State machine has two states, ACCUM and HOLD. Reset puts it in ACCUM.
- Reset values: acc=0, cnt=0, out_valid=0, out_data=0, out_len=0, out_sat=0.
- in_ready = (state==ACCUM). It is therefore 1 immediately after reset deasserts.
- Accepted beat: in_valid & in_ready at the rising edge of clk.
- ACCUM, beat accepted, not closing:
  - acc <= acc + zero-extended in_prod.
  - cnt <= cnt + 1.
- Closing condition: in_last==1 OR cnt+1==MAX_LEN. On a closing beat:
  - out_data <= acc + in_prod.
  - out_len <= cnt + 1.
  - out_valid <= 1.
  - acc <= 0, cnt <= 0.
  - state <= HOLD.
- Latency: result valid exactly one cycle after the closing beat is accepted.
- HOLD:
  - in_ready=0; upstream must hold its beat.
  - out_data, out_len and out_sat stay stable while out_valid & !out_ready.
  - When out_ready=1, out_valid clears at the next edge and state returns to ACCUM.
  - in_ready is 1 in the cycle after the handshake, so each group costs at least one bubble cycle.
- Throughput in ACCUM: one beat per cycle, with no bubbles inside a group.
- in_valid=0 in ACCUM leaves acc and cnt unchanged; idle gaps inside a group are allowed.
- in_last on the MAX_LEN-th beat closes the group once; out_len=MAX_LEN.
- MAX_LEN==1: every beat closes; out_len is always 1.
- Arithmetic (no SAT_EN): unsigned, modulo 2^ACC_W. Wrap is silent.
- rst asserted mid-group or in HOLD:
  - All state clears immediately (asynchronously).
  - The partial sum is discarded and no result is emitted.
  - out_valid drops at once.
- in_prod and in_last are ignored when not accepted, including all of HOLD.

Optional Feature:
- Macro: APPROX_ACC_SAT_EN.
- Defined:
  - Each addition detects a carry out of ACC_W bits.
  - On carry, the sum clamps to 2^ACC_W-1 and a sticky group saturation flag sets.
  - Subsequent beats in the group keep the value clamped.
  - out_sat is registered with out_data on the closing beat and clears together with acc.
- Not defined:
  - Modulo wrap as above; out_sat is constant 0.
  - No saturation logic is synthesized.

Test Plan:
- Reset then idle: after rst deasserts -> in_ready=1, out_valid=0, out_data=0, out_len=0 for 10 cycles.
- Basic group, ACC_W=24: beats 100, 200, 300 on consecutive cycles, last on the third -> one cycle later out_valid=1, out_data=600, out_len=3; in_ready=0 until the out_ready handshake.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_data/out_len stable, in_ready=0, no extra beats absorbed; out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- Max length, MAX_LEN=16: 16 beats of 0xFFFF with in_last never asserted -> out_len=16, out_data=0x0FFFF0; the 17th beat starts a new group from 0.
- Overflow, ACC_W=16: beats 0xFFFF and 0x0002 with last -> out_data=0x0001, out_sat=0 without the macro; 0xFFFF and out_sat=1 with APPROX_ACC_SAT_EN defined.
- Reset mid-group: accept 2 beats of 50, assert rst for 1 cycle, then send a group of a single beat of 7 with last -> out_data=7, out_len=1, no stale result emitted.

Source files
------------

// File: rtl/approx_prod_accumulator.sv
// approx_prod_accumulator
//   Sums a group of unsigned products from the approximate multiplier into a
//   wide accumulator. It emits one result per group on an output stream.
//   A group closes on in_last, or when MAX_LEN beats have been accepted.
//
// Handshake rule, used on both streams:
//   A transfer happens at a rising clk edge where valid & ready are both 1.
//   While valid is 1 and ready is 0, the producer holds its payload stable.
//   The result stream is registered. out_data, out_len and out_sat stay stable
//   while out_valid & !out_ready. in_ready depends only on the FSM state and
//   never on in_valid.
//
// Optional feature, compile-time macro APPROX_ACC_SAT_EN:
//   defined   -> each addition clamps to 2^ACC_W-1 on carry-out, and a sticky
//                per-group flag is reported on out_sat
//   undefined -> silent modulo-2^ACC_W wrap; out_sat is tied to 0
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   product beat valid
//   in_ready   out  block can accept a beat (state == ACCUM)
//   in_prod    in   [PROD_W] unsigned product
//   in_last    in   beat closes the group
//   out_valid  out  group result valid
//   out_ready  in   downstream accepts the result
//   out_data   out  [ACC_W] group sum
//   out_len    out  [CNT_W] beats in the group (1..MAX_LEN)
//   out_sat    out  group saturated (APPROX_ACC_SAT_EN only)
//   dbg_state  out  FSM state (0 = ACCUM, 1 = HOLD)
module approx_prod_accumulator #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_len,
  output logic              out_sat,
  output logic              dbg_state
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [ACC_W-1:0]   r_out_data;
  logic [CNT_W-1:0]   r_out_len;

  logic               w_accept;
  logic               w_close;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [ACC_W-1:0]   w_sum;

  assign in_ready  = (r_state == ST_ACCUM);
  assign w_accept  = in_valid & in_ready;
  assign w_cnt_inc = r_cnt + 1'b1;
  // A beat that fills the group to MAX_LEN closes it, even without in_last.
  assign w_close   = in_last | (w_cnt_inc == MAX_CNT);

`ifdef APPROX_ACC_SAT_EN
  logic [ACC_W:0] w_sum_wide;
  logic           w_sat_now;
  logic           r_sat;
  logic           r_out_sat;

  // One extra bit catches the carry. On a carry the sum pins to all-ones.
  // Once pinned, any later non-zero beat carries again, so the value stays
  // clamped for the rest of the group.
  assign w_sum_wide = {1'b0, r_acc} + (ACC_W+1)'(in_prod);
  assign w_sum      = w_sum_wide[ACC_W] ? {ACC_W{1'b1}} : w_sum_wide[ACC_W-1:0];
  assign w_sat_now  = r_sat | w_sum_wide[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat     <= 1'b0;
      r_out_sat <= 1'b0;
    end else if (w_accept) begin
      if (w_close) begin
        r_out_sat <= w_sat_now;
        r_sat     <= 1'b0;
      end else begin
        r_sat     <= w_sat_now;
      end
    end
  end

  assign out_sat = r_out_sat;
`else
  assign w_sum   = r_acc + ACC_W'(in_prod);
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_len   <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            if (w_close) begin
              r_out_data  <= w_sum;
              r_out_len   <= w_cnt_inc;
              r_out_valid <= 1'b1;
              r_acc       <= '0;
              r_cnt       <= '0;
              r_state     <= ST_HOLD;
            end else begin
              r_acc <= w_sum;
              r_cnt <= w_cnt_inc;
            end
          end
        end
        ST_HOLD: begin
          // The result payload is left untouched here, so it stays stable
          // under backpressure.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
          end
        end
        default: r_state <= ST_ACCUM;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_len   = r_out_len;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Bench for approx_prod_accumulator. It uses three instances that share clk
// and rst:
//   dut   : ACC_W=24, MAX_LEN=16 (main instance, table + random reference model)
//   dut_b : ACC_W=16, MAX_LEN=16 (overflow / saturation corner)
//   dut_c : ACC_W=24, MAX_LEN=1  (every beat closes)
module tb_approx_prod_accumulator;

  localparam int PROD_W  = 16;
  localparam int ACC_W   = 24;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int B_ACC_W = 16;
  localparam int C_CNT_W = 1;
  localparam int EXP_W   = ACC_W + CNT_W + 1;

`ifdef APPROX_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              in_valid, in_ready, in_last, out_valid, out_ready, out_sat, dbg_state;
  logic [PROD_W-1:0] in_prod;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_len;

  logic               b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_sat, b_dbg;
  logic [PROD_W-1:0]  b_in_prod;
  logic [B_ACC_W-1:0] b_out_data;
  logic [CNT_W-1:0]   b_out_len;

  logic               c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_sat, c_dbg;
  logic [PROD_W-1:0]  c_in_prod;
  logic [ACC_W-1:0]   c_out_data;
  logic [C_CNT_W-1:0] c_out_len;

  approx_prod_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_len(out_len), .out_sat(out_sat), .dbg_state(dbg_state)
  );

  approx_prod_accumulator #(.PROD_W(PROD_W), .ACC_W(B_ACC_W), .MAX_LEN(MAX_LEN)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_len(b_out_len), .out_sat(b_out_sat), .dbg_state(b_dbg)
  );

  approx_prod_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .MAX_LEN(1)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_prod(c_in_prod), .in_last(c_in_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_len(c_out_len), .out_sat(c_out_sat), .dbg_state(c_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Group sum as the specification defines it. All beats are non-negative,
  // so clamping the final total is the same as clamping each addition.
  function automatic longint grp_sum(input longint s, input int accw);
    longint lim;
    lim = (longint'(1) << accw) - 1;
    if (SAT_EN) return (s > lim) ? lim : s;
    return s & lim;
  endfunction

  function automatic bit grp_sat(input longint s, input int accw);
    return SAT_EN && (s > ((longint'(1) << accw) - 1));
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change, and outputs are sampled, 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [PROD_W-1:0] p, input logic last);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [ACC_W-1:0] d, input logic [CNT_W-1:0] l);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_len"}, out_len, l);
    chk({name, "_sat"}, out_sat, 1'b0);
    chk({name, "_in_ready_hold"}, in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_valid_clr"}, out_valid, 1'b0);
    chk({name, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic b_beat(input logic [PROD_W-1:0] p, input logic last);
    b_in_valid = 1'b1;
    b_in_prod  = p;
    b_in_last  = last;
    step();
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic c_beat(input logic [PROD_W-1:0] p, input logic last, input logic [ACC_W-1:0] d);
    c_in_valid = 1'b1;
    c_in_prod  = p;
    c_in_last  = last;
    step();
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;
    chk("len1_valid", c_out_valid, 1'b1);
    chk("len1_data", c_out_data, d);
    chk("len1_len", c_out_len, 1'b1);
    chk("len1_in_ready", c_in_ready, 1'b0);
    c_out_ready = 1'b1;
    step();
    c_out_ready = 1'b0;
    chk("len1_valid_clr", c_out_valid, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [PROD_W-1:0] prod;
    logic              last;
    logic              close;
    logic [ACC_W-1:0]  data;
    logic [CNT_W-1:0]  len;
  } beat_vec_t;

  beat_vec_t vecs[9];

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    longint m_sum;
    int     m_len;
    bit     m_hold;
    longint bsum;

    rst = 1'b1;
    in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_prod = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_prod = '0; c_in_last = 1'b0; c_out_ready = 1'b0;

    vecs[0] = '{16'd100,   1'b0, 1'b0, 24'd0,       5'd0};
    vecs[1] = '{16'd200,   1'b0, 1'b0, 24'd0,       5'd0};
    vecs[2] = '{16'd300,   1'b1, 1'b1, 24'd600,     5'd3};
    vecs[3] = '{16'd5,     1'b1, 1'b1, 24'd5,       5'd1};
    vecs[4] = '{16'hFFFF,  1'b0, 1'b0, 24'd0,       5'd0};
    vecs[5] = '{16'h0001,  1'b1, 1'b1, 24'h010000,  5'd2};
    vecs[6] = '{16'h0000,  1'b1, 1'b1, 24'd0,       5'd1};
    vecs[7] = '{16'h1234,  1'b0, 1'b0, 24'd0,       5'd0};
    vecs[8] = '{16'h4321,  1'b1, 1'b1, 24'h005555,  5'd2};

    // Reset values
    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_len", out_len, '0);
    chk("rst_out_sat", out_sat, 1'b0);
    chk("rst_dbg_state", dbg_state, 1'b0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_c_out_valid", c_out_valid, 1'b0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_out_data", out_data, '0);
      chk("idle_out_len", out_len, '0);
    end

    // Table: back-to-back beats, each closing beat handshaked at once
    for (int i = 0; i < 9; i++) begin
      send_beat(vecs[i].prod, vecs[i].last);
      if (vecs[i].close) expect_result("tbl", vecs[i].data, vecs[i].len);
      else begin
        chk("tbl_open_valid", out_valid, 1'b0);
        chk("tbl_open_in_ready", in_ready, 1'b1);
      end
    end

    // Backpressure: result held 5 cycles while upstream keeps offering a beat
    send_beat(16'd1, 1'b0);
    send_beat(16'd2, 1'b0);
    send_beat(16'd3, 1'b1);
    in_valid = 1'b1; in_prod = 16'd999; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 24'd6);
      chk("bp_len", out_len, 5'd3);
      chk("bp_in_ready", in_ready, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_release_valid", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);
    send_beat(16'd10, 1'b1);
    expect_result("bp_next", 24'd10, 5'd1);

    // Max length without in_last, then the next beat starts from zero
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i == MAX_LEN - 1) chk("max_open_valid", out_valid, 1'b0);
      send_beat(16'hFFFF, 1'b0);
    end
    expect_result("max_len", 24'h0FFFF0, 5'd16);
    send_beat(16'd1, 1'b1);
    expect_result("max_after", 24'd1, 5'd1);

    // in_last on the MAX_LEN-th beat closes exactly once
    for (int i = 0; i < MAX_LEN; i++) send_beat(16'd2, (i == MAX_LEN - 1));
    expect_result("max_last", 24'd32, 5'd16);
    step();
    chk("max_last_no_dup", out_valid, 1'b0);

    // Idle gaps inside a group
    send_beat(16'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gap_valid", out_valid, 1'b0);
    end
    send_beat(16'd20, 1'b1);
    expect_result("gap", 24'd30, 5'd2);

    // Reset mid-group discards the partial sum
    send_beat(16'd50, 1'b0);
    send_beat(16'd50, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_valid", out_valid, 1'b0);
    send_beat(16'd7, 1'b1);
    expect_result("rstmid", 24'd7, 5'd1);

    // Reset in HOLD drops out_valid without waiting for a clock edge
    send_beat(16'd9, 1'b1);
    chk("rsthold_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rsthold_async_valid", out_valid, 1'b0);
    chk("rsthold_async_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();
    chk("rsthold_after_valid", out_valid, 1'b0);

    // Overflow at ACC_W=16: three beats, the carry happens on the second
    b_beat(16'hFFFF, 1'b0);
    b_beat(16'h0002, 1'b0);
    b_beat(16'h0005, 1'b1);
    bsum = 64'hFFFF + 64'h2 + 64'h5;
    chk("ovf_valid", b_out_valid, 1'b1);
    chk("ovf_data", b_out_data, grp_sum(bsum, B_ACC_W));
    chk("ovf_sat", b_out_sat, grp_sat(bsum, B_ACC_W));
    chk("ovf_len", b_out_len, 5'd3);
    chk("ovf_dbg", b_dbg, 1'b1);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("ovf_valid_clr", b_out_valid, 1'b0);
    b_beat(16'hFFFF, 1'b0);
    b_beat(16'h0002, 1'b1);
    chk("ovf2_data", b_out_data, SAT_EN ? 16'hFFFF : 16'h0001);
    chk("ovf2_sat", b_out_sat, SAT_EN);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    b_beat(16'd3, 1'b1);
    chk("ovf_clear_data", b_out_data, 16'd3);
    chk("ovf_clear_sat", b_out_sat, 1'b0);
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    chk("ovf_clear_in_ready", b_in_ready, 1'b1);

    // MAX_LEN=1: every beat closes
    c_beat(16'd9, 1'b0, 24'd9);
    c_beat(16'd4, 1'b1, 24'd4);
    chk("len1_sat", c_out_sat, 1'b0);
    chk("len1_dbg", c_dbg, 1'b0);

    // Random stimulus against the reference model
    m_sum = 0; m_len = 0; m_hold = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_in_ready", in_ready, !m_hold);
      chk("rnd_out_valid", out_valid, m_hold);
      chk("rnd_dbg_state", dbg_state, m_hold);
      if (m_hold) chk("rnd_result", {out_data, out_len, out_sat}, exp_q[0]);

      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 1) == 1);

      if (!m_hold && in_valid) begin
        m_sum = m_sum + longint'(in_prod);
        m_len = m_len + 1;
        if (in_last || m_len == MAX_LEN) begin
          exp_q.push_back({ACC_W'(grp_sum(m_sum, ACC_W)), CNT_W'(m_len), grp_sat(m_sum, ACC_W)});
          m_hold = 1'b1;
          m_sum  = 0;
          m_len  = 0;
        end
      end else if (m_hold && out_ready) begin
        m_hold = 1'b0;
        void'(exp_q.pop_front());
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
